commit_window_rob: RTL and testbench
====================================

Name: commit_window_rob

Overview:
- Small in-order reorder window between issue and commit.
- Sized by the core configuration: NrScoreboardEntries (8) slots, NrCommitPorts (2) retire ports, XLEN (64) PCs.
- Allocates one slot per issued instruction, records out-of-order writebacks, and presents the oldest completed instructions to commit in program order.

Parameters:
- XLEN, 64, PC width.
- NR_ENTRIES, 8, window depth; power of two, at least 2.
- NR_COMMIT_PORTS, 2, retire ports; 1 or 2.
- TRANS_ID_W, $clog2(NR_ENTRIES), slot index width.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all in-flight entries.
- issue_valid_i  in  1  new instruction offered.
- issue_ready_o  out  1  free slot available.
- issue_pc_i  in  XLEN  PC of the offered instruction.
- issue_trans_id_o  out  TRANS_ID_W  slot index given to the offered instruction.
- wb_valid_i  in  1  writeback strobe.
- wb_trans_id_i  in  TRANS_ID_W  slot being written back.
- wb_ex_i  in  1  writeback carries an exception.
- commit_valid_o  out  NR_COMMIT_PORTS  per-port retire candidate valid.
- commit_pc_o  out  NR_COMMIT_PORTS*XLEN  per-port PC; port k occupies bits [k*XLEN +: XLEN].
- commit_ex_o  out  NR_COMMIT_PORTS  per-port exception flag.
- commit_ack_i  in  NR_COMMIT_PORTS  per-port retire acknowledge.
- count_o  out  TRANS_ID_W+1  occupied slots.

Behaviour:
- State: per slot {alloc, done, ex, pc}; issue_ptr, commit_ptr (TRANS_ID_W bits, natural wrap); count register.
- Reset (async, rst_ni=0): all alloc/done/ex = 0, pointers = 0, count = 0.
  - Output reset values: issue_ready_o=1, commit_valid_o=0, commit_ex_o=0, commit_pc_o=0, count_o=0, issue_trans_id_o=0.
- Issue:
  - issue_ready_o = (count != NR_ENTRIES), registered state only; no combinational path from commit_ack_i or issue_valid_i.
  - issue_trans_id_o = issue_ptr.
  - Handshake fires when valid&&ready: slot[issue_ptr] <- {alloc=1, done=0, ex=0, pc}; issue_ptr+1.
- Writeback:
  - wb_valid_i to an allocated, not-done slot sets done=1 and ex=wb_ex_i.
  - Writeback to an unallocated or already-done slot is ignored.
  - A writeback in the same cycle as issue to the same slot is ignored; the issue wins.
- Commit candidates:
  - Port k looks at slot commit_ptr+k (wraps).
  - Valid if alloc && done, and all lower ports are valid.
  - Port k>0 is additionally invalid if port 0 has ex=1 or its own slot has ex=1. Exceptions retire alone on port 0.
  - commit_pc_o/commit_ex_o are driven from slot contents; they are zero when the port is invalid.
  - Latency: a writeback at cycle t shows on commit_valid_o at t+1. An issue at t is earliest committable at t+2.
- Retire:
  - Retired count r = length of the contiguous prefix of ports where commit_ack_i && commit_valid_o.
  - Ack bits beyond the first zero are ignored. An ack on an invalid port is ignored.
  - Retired slots are cleared (alloc=0, done=0); commit_ptr += r.
- Count:
  - count_next = count + issue_fire - r.
  - Simultaneous issue and retire while full: issue_ready_o=0, so no issue; retire proceeds.
- Flush:
  - flush_i is synchronous. Next cycle: all alloc/done = 0, pointers = 0, count = 0.
  - Flush overrides issue, writeback and commit in the same cycle; commit outputs are still driven combinationally that cycle.
- Empty: commit_valid_o=0 regardless of wb_valid_i.
- Full: count=NR_ENTRIES, issue_ready_o=0.

Optional Feature:
- Macro: CVA6_ROB_STALL_CNT_EN.
- When defined:
  - Adds port stall_cnt_o (out, 32): counts cycles with issue_valid_i=1 && issue_ready_o=0.
  - Saturates at 0xFFFFFFFF; reset to 0 by rst_ni and by flush_i.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (cva6_rob_pkg): rob_entry_t {alloc, done, ex, pc[XLEN-1:0]}; constants ROB_DEPTH, ROB_COMMIT_PORTS.
  - These constants derive from the core configuration values (NrScoreboardEntries, NrCommitPorts, XLEN).
- Sub-module rob_commit_select: purely combinational. Takes the slots at commit_ptr..commit_ptr+NR_COMMIT_PORTS-1 and commit_ack_i; produces commit_valid_o and r.
- Storage and pointers stay in the top module.

Test Plan:
- Reset: hold rst_ni=0 with random inputs -> issue_ready_o=1, commit_valid_o=00, count_o=0.
- Fill:
  - Issue 8 PCs 0x1000..0x101C with no writeback -> trans_ids 0..7; count_o=8, issue_ready_o=0.
  - 9th issue_valid_i held -> no allocation; stall_cnt_o increments per cycle when enabled.
- Out-of-order writeback:
  - Write back slot 1, then slot 0 -> after slot 1 alone commit_valid_o=00.
  - After slot 0: commit_valid_o=11 with PCs 0x1000/0x1004.
  - Ack=11 -> commit_ptr=2, count_o=6.
- Exception isolation:
  - Slots 2 (ex=1) and 3 (ex=0) done -> commit_valid_o=01, commit_ex_o=01.
  - After ack=01 -> slot 3 is offered on port 0.
- Partial/illegal ack: two valid ports, ack=10 -> nothing retires, commit_ptr unchanged.
- Wrap and flush:
  - Issue and retire 13 entries -> pointers wrap, PCs stay in order.
  - flush_i with count_o=5 and simultaneous issue -> next cycle count_o=0, issue_trans_id_o=0.

Source files
------------

// File: rtl/cva6_rob_pkg.sv
// Shared types and sizing for the commit window reorder buffer.
// Sizes are taken from the core configuration (scoreboard entries, commit ports, XLEN).
package cva6_rob_pkg;

  localparam int unsigned NrScoreboardEntries = 8;
  localparam int unsigned NrCommitPorts       = 2;
  localparam int unsigned CfgXlen             = 64;

  localparam int unsigned ROB_DEPTH        = NrScoreboardEntries;
  localparam int unsigned ROB_COMMIT_PORTS = NrCommitPorts;
  localparam int unsigned ROB_XLEN         = CfgXlen;

  typedef struct packed {
    logic                alloc;
    logic                done;
    logic                ex;
    logic [ROB_XLEN-1:0] pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// Commit candidate selection: decides which head slots may retire this cycle
// and how many actually retire given the per-port acknowledges.
module rob_commit_select #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned RET_W           = $clog2(NR_COMMIT_PORTS + 1)
) (
  input  logic [NR_COMMIT_PORTS-1:0] slot_alloc_i,
  input  logic [NR_COMMIT_PORTS-1:0] slot_done_i,
  input  logic [NR_COMMIT_PORTS-1:0] slot_ex_i,
  input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
  output logic [NR_COMMIT_PORTS-1:0] commit_valid_o,
  output logic [RET_W-1:0]           retire_cnt_o
);

  logic [NR_COMMIT_PORTS-1:0] valid;
  logic                       in_prefix;

  always_comb begin
    // NOTE: every output and temporary gets a default before any branch, so no
    // path through the block leaves a value held over and no latch is inferred.
    valid        = '0;
    retire_cnt_o = '0;
    in_prefix    = 1'b1;

    valid[0] = slot_alloc_i[0] && slot_done_i[0];
    // An exception on the head must retire alone, so it blocks every younger port.
    for (int k = 1; k < NR_COMMIT_PORTS; k++) begin
      valid[k] = valid[k-1] && slot_alloc_i[k] && slot_done_i[k] &&
                 !slot_ex_i[0] && !slot_ex_i[k];
    end

    // NOTE: blocking assignments are used on purpose in combinational logic:
    // the count accumulates within one evaluation of the block.
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (in_prefix && valid[k] && commit_ack_i[k]) begin
        retire_cnt_o = retire_cnt_o + RET_W'(1);
      end else begin
        in_prefix = 1'b0;
      end
    end

    commit_valid_o = valid;
  end

endmodule

// File: rtl/commit_window_rob.sv
// In-order reorder window between issue and commit with out-of-order writeback.
// Optional issue-stall cycle counter enabled by defining CVA6_ROB_STALL_CNT_EN.
module commit_window_rob
  import cva6_rob_pkg::*;
#(
  parameter int unsigned XLEN            = ROB_XLEN,
  parameter int unsigned NR_ENTRIES      = ROB_DEPTH,
  parameter int unsigned NR_COMMIT_PORTS = ROB_COMMIT_PORTS,
  parameter int unsigned TRANS_ID_W      = $clog2(NR_ENTRIES)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [XLEN-1:0]                 issue_pc_i,
  output logic [TRANS_ID_W-1:0]           issue_trans_id_o,
  input  logic                            wb_valid_i,
  input  logic [TRANS_ID_W-1:0]           wb_trans_id_i,
  input  logic                            wb_ex_i,
  output logic [NR_COMMIT_PORTS-1:0]      commit_valid_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0] commit_pc_o,
  output logic [NR_COMMIT_PORTS-1:0]      commit_ex_o,
  input  logic [NR_COMMIT_PORTS-1:0]      commit_ack_i,
  output logic [TRANS_ID_W:0]             count_o
`ifdef CVA6_ROB_STALL_CNT_EN
  ,
  output logic [31:0]                     stall_cnt_o
`endif
);

  localparam int unsigned CNT_W = TRANS_ID_W + 1;
  localparam int unsigned RET_W = $clog2(NR_COMMIT_PORTS + 1);

  rob_entry_t              slots_q [NR_ENTRIES];
  logic [TRANS_ID_W-1:0]   issue_ptr_q;
  logic [TRANS_ID_W-1:0]   commit_ptr_q;
  logic [CNT_W-1:0]        count_q;

  logic                       issue_fire;
  logic                       wb_accept;
  logic [TRANS_ID_W-1:0]      port_idx [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] port_alloc;
  logic [NR_COMMIT_PORTS-1:0] port_done;
  logic [NR_COMMIT_PORTS-1:0] port_ex;
  logic [NR_COMMIT_PORTS-1:0] commit_valid;
  logic [RET_W-1:0]           retire_cnt;

  // Ready depends only on registered occupancy, never on this cycle's acks.
  assign issue_ready_o    = (count_q != CNT_W'(NR_ENTRIES));
  assign issue_trans_id_o = issue_ptr_q;
  assign issue_fire       = issue_valid_i && issue_ready_o;
  assign count_o          = count_q;

  // A writeback racing the issue into the same slot refers to the old occupant.
  assign wb_accept = wb_valid_i &&
                     slots_q[wb_trans_id_i].alloc &&
                     !slots_q[wb_trans_id_i].done &&
                     !(issue_fire && (wb_trans_id_i == issue_ptr_q));

  always_comb begin
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      port_idx[k]   = commit_ptr_q + TRANS_ID_W'(k);
      port_alloc[k] = slots_q[port_idx[k]].alloc;
      port_done[k]  = slots_q[port_idx[k]].done;
      port_ex[k]    = slots_q[port_idx[k]].ex;
    end
  end

  rob_commit_select #(
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
    .RET_W           (RET_W)
  ) u_commit_select (
    .slot_alloc_i   (port_alloc),
    .slot_done_i    (port_done),
    .slot_ex_i      (port_ex),
    .commit_ack_i   (commit_ack_i),
    .commit_valid_o (commit_valid),
    .retire_cnt_o   (retire_cnt)
  );

  always_comb begin
    commit_valid_o = commit_valid;
    commit_pc_o    = '0;
    commit_ex_o    = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (commit_valid[k]) begin
        commit_pc_o[k*XLEN +: XLEN] = slots_q[port_idx[k]].pc;
        commit_ex_o[k]              = port_ex[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the window is only a handful of slots, so the whole array is reset;
      // the flags must be cleared, and clearing pc too keeps commit_pc_o defined.
      for (int i = 0; i < NR_ENTRIES; i++) begin
        slots_q[i] <= '0;
      end
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        slots_q[i].alloc <= 1'b0;
        slots_q[i].done  <= 1'b0;
        slots_q[i].ex    <= 1'b0;
      end
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
    end else begin
      // Retiring, written-back and newly issued slots are always distinct.
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
        if (RET_W'(k) < retire_cnt) begin
          slots_q[port_idx[k]].alloc <= 1'b0;
          slots_q[port_idx[k]].done  <= 1'b0;
        end
      end
      if (wb_accept) begin
        slots_q[wb_trans_id_i].done <= 1'b1;
        slots_q[wb_trans_id_i].ex   <= wb_ex_i;
      end
      if (issue_fire) begin
        slots_q[issue_ptr_q] <= '{alloc: 1'b1, done: 1'b0, ex: 1'b0, pc: issue_pc_i};
      end
      issue_ptr_q  <= issue_ptr_q + TRANS_ID_W'(issue_fire);
      commit_ptr_q <= commit_ptr_q + TRANS_ID_W'(retire_cnt);
      count_q      <= count_q + CNT_W'(issue_fire) - CNT_W'(retire_cnt);
    end
  end

`ifdef CVA6_ROB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (flush_i) begin
      stall_cnt_q <= '0;
    end else if (issue_valid_i && !issue_ready_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_commit_window_rob.sv
// Self-checking bench for commit_window_rob: PC scoreboard checked at retire,
// scenario tasks for fill, out-of-order writeback, exceptions, acks, wrap and flush.
module tb_commit_window_rob;

  localparam int XLEN = 64;
  localparam int TW   = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [XLEN-1:0] issue_pc_i;
  logic [TW-1:0]   issue_trans_id_o;
  logic            wb_valid_i;
  logic [TW-1:0]   wb_trans_id_i;
  logic            wb_ex_i;
  logic [1:0]      commit_valid_o;
  logic [2*XLEN-1:0] commit_pc_o;
  logic [1:0]      commit_ex_o;
  logic [1:0]      commit_ack_i;
  logic [TW:0]     count_o;
`ifdef CVA6_ROB_STALL_CNT_EN
  logic [31:0]     stall_cnt_o;
`endif

  commit_window_rob dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .issue_pc_i       (issue_pc_i),
    .issue_trans_id_o (issue_trans_id_o),
    .wb_valid_i       (wb_valid_i),
    .wb_trans_id_i    (wb_trans_id_i),
    .wb_ex_i          (wb_ex_i),
    .commit_valid_o   (commit_valid_o),
    .commit_pc_o      (commit_pc_o),
    .commit_ex_o      (commit_ex_o),
    .commit_ack_i     (commit_ack_i),
    .count_o          (count_o)
`ifdef CVA6_ROB_STALL_CNT_EN
    ,
    .stall_cnt_o      (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [XLEN-1:0] sb_q[$];    // PCs expected to retire, oldest first
  logic [TW-1:0]   pend_q[$];  // slots allocated but not yet written back
  logic [TW-1:0]   m_issue_ptr;
  logic [XLEN-1:0] exp_pc;

  function automatic void pend_remove(input logic [TW-1:0] id);
    for (int i = 0; i < pend_q.size(); i++) begin
      if (pend_q[i] == id) begin
        pend_q.delete(i);
        return;
      end
    end
  endfunction

  task automatic drive_idle();
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    issue_pc_i    = '0;
    wb_valid_i    = 1'b0;
    wb_trans_id_i = '0;
    wb_ex_i       = 1'b0;
    commit_ack_i  = 2'b00;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i); #1;
      flush_i       = 1'($urandom);
      issue_valid_i = 1'($urandom);
      issue_pc_i    = {$urandom, $urandom};
      wb_valid_i    = 1'($urandom);
      wb_trans_id_i = TW'($urandom);
      wb_ex_i       = 1'($urandom);
      commit_ack_i  = 2'($urandom);
    end
    @(negedge clk_i);
    chk_cnt++; if (issue_ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", issue_ready_o); else pass_cnt++;
    chk_cnt++; if (commit_valid_o !== 2'b00) $display("FAIL reset_valid: got %b expected 00", commit_valid_o); else pass_cnt++;
    chk_cnt++; if (count_o !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count_o); else pass_cnt++;
    chk_cnt++; if (commit_pc_o !== '0 || commit_ex_o !== 2'b00 || issue_trans_id_o !== 3'd0)
      $display("FAIL reset_outputs: got pc=%h ex=%b id=%0d expected all zero", commit_pc_o, commit_ex_o, issue_trans_id_o);
    else pass_cnt++;
`ifdef CVA6_ROB_STALL_CNT_EN
    chk_cnt++; if (stall_cnt_o !== 32'd0) $display("FAIL reset_stall: got %0d expected 0", stall_cnt_o); else pass_cnt++;
`endif
    @(posedge clk_i); #1;
    drive_idle();
    #2 rst_ni = 1'b1;
    m_issue_ptr = '0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      issue_valid_i = 1'b1;
      issue_pc_i    = 64'h1000 + 64'(4 * i);
      @(negedge clk_i);
      chk_cnt++;
      if (issue_ready_o !== 1'b1 || issue_trans_id_o !== TW'(i))
        $display("FAIL fill_issue: got ready=%b id=%0d expected ready=1 id=%0d", issue_ready_o, issue_trans_id_o, i);
      else pass_cnt++;
      sb_q.push_back(issue_pc_i);
      pend_q.push_back(TW'(i));
      m_issue_ptr = m_issue_ptr + 1'b1;
    end
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
    @(negedge clk_i);
    chk_cnt++; if (count_o !== 4'd8 || issue_ready_o !== 1'b0)
      $display("FAIL fill_full: got count=%0d ready=%b expected count=8 ready=0", count_o, issue_ready_o);
    else pass_cnt++;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk_i); #1;
      issue_valid_i = 1'b1;
      issue_pc_i    = 64'h1020;
      @(negedge clk_i);
      chk_cnt++; if (issue_ready_o !== 1'b0) $display("FAIL full_stall_ready: got %b expected 0", issue_ready_o); else pass_cnt++;
    end
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
    @(negedge clk_i);
    chk_cnt++; if (count_o !== 4'd8 || issue_trans_id_o !== 3'd0)
      $display("FAIL full_no_alloc: got count=%0d id=%0d expected count=8 id=0", count_o, issue_trans_id_o);
    else pass_cnt++;
`ifdef CVA6_ROB_STALL_CNT_EN
    chk_cnt++; if (stall_cnt_o !== 32'd3) $display("FAIL stall_cnt: got %0d expected 3", stall_cnt_o); else pass_cnt++;
`endif
  endtask

  task automatic test_ooo_writeback();
    @(posedge clk_i); #1;
    wb_valid_i = 1'b1; wb_trans_id_i = 3'd1; wb_ex_i = 1'b0;
    @(posedge clk_i); #1;
    wb_trans_id_i = 3'd0;
    @(negedge clk_i);
    chk_cnt++; if (commit_valid_o !== 2'b00) $display("FAIL ooo_younger_only: got %b expected 00", commit_valid_o); else pass_cnt++;
    pend_remove(3'd1);
    @(posedge clk_i); #1;
    wb_valid_i = 1'b0;
    commit_ack_i = 2'b11;
    pend_remove(3'd0);
    @(negedge clk_i);
    chk_cnt++; if (commit_valid_o !== 2'b11) $display("FAIL ooo_both_valid: got %b expected 11", commit_valid_o); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      exp_pc = sb_q.pop_front();
      chk_cnt++;
      if (commit_pc_o[k*XLEN +: XLEN] !== exp_pc || exp_pc !== 64'h1000 + 64'(4 * k))
        $display("FAIL ooo_pc%0d: got %h expected %h", k, commit_pc_o[k*XLEN +: XLEN], 64'h1000 + 64'(4 * k));
      else pass_cnt++;
    end
    @(posedge clk_i); #1;
    commit_ack_i = 2'b00;
    @(negedge clk_i);
    chk_cnt++; if (count_o !== 4'd6 || commit_valid_o !== 2'b00)
      $display("FAIL ooo_after_retire: got count=%0d valid=%b expected count=6 valid=00", count_o, commit_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_exception();
    @(posedge clk_i); #1;
    wb_valid_i = 1'b1; wb_trans_id_i = 3'd2; wb_ex_i = 1'b1;
    @(posedge clk_i); #1;
    wb_trans_id_i = 3'd3; wb_ex_i = 1'b0;
    @(posedge clk_i); #1;
    wb_trans_id_i = 3'd2; wb_ex_i = 1'b0;  // slot 2 already done: must be ignored
    @(posedge clk_i); #1;
    wb_valid_i = 1'b0;
    pend_remove(3'd2); pend_remove(3'd3);
    @(negedge clk_i);
    chk_cnt++; if (commit_valid_o !== 2'b01 || commit_ex_o !== 2'b01)
      $display("FAIL ex_alone: got valid=%b ex=%b expected valid=01 ex=01", commit_valid_o, commit_ex_o);
    else pass_cnt++;
    chk_cnt++; if (commit_pc_o[XLEN +: XLEN] !== '0) $display("FAIL ex_port1_pc: got %h expected 0", commit_pc_o[XLEN +: XLEN]); else pass_cnt++;
    @(posedge clk_i); #1;
    commit_ack_i = 2'b01;
    @(negedge clk_i);
    exp_pc = sb_q.pop_front();
    chk_cnt++; if (commit_pc_o[0 +: XLEN] !== exp_pc) $display("FAIL ex_retire_pc: got %h expected %h", commit_pc_o[0 +: XLEN], exp_pc); else pass_cnt++;
    @(posedge clk_i); #1;
    commit_ack_i = 2'b00;
    @(negedge clk_i);
    chk_cnt++;
    if (commit_valid_o !== 2'b01 || commit_ex_o !== 2'b00 || commit_pc_o[0 +: XLEN] !== sb_q[0] || count_o !== 4'd5)
      $display("FAIL ex_next_head: got valid=%b ex=%b pc=%h count=%0d expected valid=01 ex=00 pc=%h count=5",
               commit_valid_o, commit_ex_o, commit_pc_o[0 +: XLEN], count_o, sb_q[0]);
    else pass_cnt++;
  endtask

  task automatic test_partial_ack();
    @(posedge clk_i); #1;
    commit_ack_i = 2'b10;  // port 0 not acked, port 1 invalid
    wb_valid_i = 1'b1; wb_trans_id_i = 3'd4; wb_ex_i = 1'b0;
    pend_remove(3'd4);
    @(posedge clk_i); #1;
    wb_valid_i = 1'b0;
    @(negedge clk_i);
    chk_cnt++; if (commit_valid_o !== 2'b11 || count_o !== 4'd5)
      $display("FAIL partial_ack_hold: got valid=%b count=%0d expected valid=11 count=5", commit_valid_o, count_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    commit_ack_i = 2'b00;
    @(negedge clk_i);
    chk_cnt++; if (count_o !== 4'd5 || commit_pc_o[0 +: XLEN] !== 64'h100C)
      $display("FAIL partial_ack_ptr: got count=%0d pc0=%h expected count=5 pc0=100c", count_o, commit_pc_o[0 +: XLEN]);
    else pass_cnt++;
    @(posedge clk_i); #1;
    commit_ack_i = 2'b11;
    @(negedge clk_i);
    for (int k = 0; k < 2; k++) begin
      exp_pc = sb_q.pop_front();
      chk_cnt++;
      if (commit_pc_o[k*XLEN +: XLEN] !== exp_pc) $display("FAIL pair_retire_pc%0d: got %h expected %h", k, commit_pc_o[k*XLEN +: XLEN], exp_pc);
      else pass_cnt++;
    end
    @(posedge clk_i); #1;
    commit_ack_i = 2'b00;
    @(negedge clk_i);
    chk_cnt++; if (count_o !== 4'd3) $display("FAIL pair_retire_count: got %0d expected 3", count_o); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int issued = 0;
    int retired = 0;
    int cyc = 0;
    int wb_idx = 0;
    bit wb_do;
    bit in_prefix;
    while ((issued < 13 || sb_q.size() != 0) && cyc < 300) begin
      @(posedge clk_i); #1;
      issue_valid_i = (issued < 13);
      issue_pc_i    = 64'h2000 + 64'(4 * issued);
      wb_do = (pend_q.size() != 0);
      if (wb_do) wb_idx = $urandom_range(pend_q.size() - 1, 0);
      wb_valid_i    = wb_do;
      wb_trans_id_i = wb_do ? pend_q[wb_idx] : '0;
      wb_ex_i       = 1'b0;
      commit_ack_i  = 2'b11;
      @(negedge clk_i);
      chk_cnt++; if (count_o !== 4'(sb_q.size())) $display("FAIL wrap_count: got %0d expected %0d", count_o, sb_q.size()); else pass_cnt++;
      if (issue_valid_i && issue_ready_o) begin
        chk_cnt++;
        if (issue_trans_id_o !== m_issue_ptr) $display("FAIL wrap_trans_id: got %0d expected %0d", issue_trans_id_o, m_issue_ptr);
        else pass_cnt++;
      end
      in_prefix = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (in_prefix && commit_valid_o[k]) begin
          exp_pc = sb_q.pop_front();
          retired++;
          chk_cnt++;
          if (commit_pc_o[k*XLEN +: XLEN] !== exp_pc || commit_ex_o[k] !== 1'b0)
            $display("FAIL wrap_retire_pc: got %h ex=%b expected %h ex=0", commit_pc_o[k*XLEN +: XLEN], commit_ex_o[k], exp_pc);
          else pass_cnt++;
        end else begin
          in_prefix = 1'b0;
        end
      end
      if (issue_valid_i && issue_ready_o) begin
        sb_q.push_back(issue_pc_i);
        pend_q.push_back(m_issue_ptr);
        m_issue_ptr = m_issue_ptr + 1'b1;
        issued++;
      end
      if (wb_do) pend_q.delete(wb_idx);
      cyc++;
    end
    @(posedge clk_i); #1;
    drive_idle();
    @(negedge clk_i);
    chk_cnt++; if (cyc >= 300) $display("FAIL wrap_timeout: got %0d cycles expected under 300", cyc); else pass_cnt++;
    chk_cnt++; if (retired != 16 || count_o !== 4'd0)
      $display("FAIL wrap_drain: got retired=%0d count=%0d expected retired=16 count=0", retired, count_o);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      issue_valid_i = 1'b1;
      issue_pc_i    = 64'h4000 + 64'(4 * i);
      @(negedge clk_i);
      sb_q.push_back(issue_pc_i);
      pend_q.push_back(m_issue_ptr);
      m_issue_ptr = m_issue_ptr + 1'b1;
    end
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
    @(negedge clk_i);
    chk_cnt++; if (count_o !== 4'd5) $display("FAIL pre_flush_count: got %0d expected 5", count_o); else pass_cnt++;
    @(posedge clk_i); #1;
    flush_i       = 1'b1;
    issue_valid_i = 1'b1;
    issue_pc_i    = 64'h5000;
    wb_valid_i    = 1'b1;
    wb_trans_id_i = pend_q[0];
    commit_ack_i  = 2'b11;
    @(posedge clk_i); #1;
    drive_idle();
    sb_q.delete();
    pend_q.delete();
    m_issue_ptr = '0;
    @(negedge clk_i);
    chk_cnt++; if (count_o !== 4'd0 || issue_trans_id_o !== 3'd0 || issue_ready_o !== 1'b1 || commit_valid_o !== 2'b00)
      $display("FAIL flush_state: got count=%0d id=%0d ready=%b valid=%b expected 0 0 1 00",
               count_o, issue_trans_id_o, issue_ready_o, commit_valid_o);
    else pass_cnt++;
`ifdef CVA6_ROB_STALL_CNT_EN
    chk_cnt++; if (stall_cnt_o !== 32'd0) $display("FAIL flush_stall: got %0d expected 0", stall_cnt_o); else pass_cnt++;
`endif
  endtask

  task automatic test_back_to_back();
    @(posedge clk_i); #1;
    wb_valid_i = 1'b1; wb_trans_id_i = 3'd0;  // empty window: ignored
    @(posedge clk_i); #1;
    issue_valid_i = 1'b1; issue_pc_i = 64'h3000;  // same-cycle writeback to the issued slot: ignored
    @(negedge clk_i);
    chk_cnt++; if (commit_valid_o !== 2'b00) $display("FAIL empty_wb: got %b expected 00", commit_valid_o); else pass_cnt++;
    sb_q.push_back(issue_pc_i);
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0; wb_valid_i = 1'b0;
    @(negedge clk_i);
    chk_cnt++; if (commit_valid_o !== 2'b00 || count_o !== 4'd1)
      $display("FAIL issue_wins_wb: got valid=%b count=%0d expected valid=00 count=1", commit_valid_o, count_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    wb_valid_i = 1'b1; wb_trans_id_i = 3'd0;
    @(posedge clk_i); #1;
    wb_valid_i = 1'b0;
    commit_ack_i = 2'b01;
    @(negedge clk_i);
    exp_pc = sb_q.pop_front();
    chk_cnt++; if (commit_valid_o !== 2'b01 || commit_pc_o[0 +: XLEN] !== exp_pc)
      $display("FAIL wb_latency: got valid=%b pc=%h expected valid=01 pc=%h", commit_valid_o, commit_pc_o[0 +: XLEN], exp_pc);
    else pass_cnt++;
    @(posedge clk_i); #1;
    commit_ack_i = 2'b00;
    @(negedge clk_i);
    chk_cnt++; if (count_o !== 4'd0 || issue_trans_id_o !== 3'd1)
      $display("FAIL b2b_drain: got count=%0d id=%0d expected count=0 id=1", count_o, issue_trans_id_o);
    else pass_cnt++;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_fill();
    test_ooo_writeback();
    test_exception();
    test_partial_ack();
    test_wrap();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t expected finish earlier", $time);
    $fatal(1);
  end

endmodule
